spi_target: RTL and testbench

SPI responder (slave) matching the team's APB-programmed SPI controller. Each transaction is one address byte followed by one data byte, both MSB-first. Writes update an internal register file. Reads return register contents on MISO. The block runs entirely on the system clock by oversampling SCLK, CS and MOSI, and sits on the peripheral side of the controller's `sclk_o`/`mosi_o`/`miso_i`/`cs_o` lines.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_if.sv | 29 ++
 rtl/spi_sync_edge.sv | 39 +++
 rtl/spi_target.sv | 193 +++++++++++++++++++
 tb/tb_spi_target.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the SPI responder.
//   state_t        one-hot FSM state encoding
//   WIDTH          default address/data byte width
//   RD_BIT         address bit that selects read (1) or write (0)
//   addr_in_range  true when the low address bits select an existing entry
package spi_pkg;

  localparam int WIDTH  = 8;
  localparam int RD_BIT = 7;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_ADDR = 4'b0010,
    S_DATA = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  // Only the bits below the read/write flag take part in the range test, so
  // an address such as 0x0A is rejected even though its low index bits alias
  // a real entry.
  function automatic logic addr_in_range(input logic [RD_BIT-1:0] addr_low,
                                         input int depth);
    return int'(addr_low) < depth;
  endfunction

endpackage

// File: rtl/spi_if.sv
// spi_if: pin-level bundle between an SPI controller and the responder.
//   sclk_i/cs_n_i/mosi_i   controller -> responder (SPI mode 0, CS active-low)
//   miso_o/miso_oe_o       responder -> controller serial data and drive enable
//   wr_valid_o/wr_addr_o/wr_data_o  completed register-write notification
// Modports: master drives the SPI pins, slave is the responder side.
interface spi_if #(
  parameter int WIDTH = spi_pkg::WIDTH
);

  logic             sclk_i;
  logic             cs_n_i;
  logic             mosi_i;
  logic             miso_o;
  logic             miso_oe_o;
  logic             wr_valid_o;
  logic [WIDTH-1:0] wr_addr_o;
  logic [WIDTH-1:0] wr_data_o;

  modport master (
    output sclk_i, cs_n_i, mosi_i,
    input  miso_o, miso_oe_o, wr_valid_o, wr_addr_o, wr_data_o
  );

  modport slave (
    input  sclk_i, cs_n_i, mosi_i,
    output miso_o, miso_oe_o, wr_valid_o, wr_addr_o, wr_data_o
  );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: two-flop synchroniser followed by an edge detector.
//   pclk_i, prst_i  system clock, asynchronous active-high reset
//   din             asynchronous input pin
//   level           synchronised level, aligned with the strobes
//   rise / fall     single-cycle strobes, 3 pclk_i cycles after the pin edge
// RST_VAL is the pin's idle level, so leaving reset never fakes an edge.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic pclk_i,
  input  logic prst_i,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // [0],[1] form the synchroniser; [2] is the previous synchronised value
  logic [2:0] sync_reg;
  logic       rise_reg;
  logic       fall_reg;

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      sync_reg <= {3{RST_VAL}};
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[1:0], din};
      rise_reg <= sync_reg[1] & ~sync_reg[2];
      fall_reg <= ~sync_reg[1] & sync_reg[2];
    end
  end

  assign level = sync_reg[2];
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder with a small register file.
// One transaction = address byte then data byte, MSB first. Address bit 7
// selects read (1) or write (0); the low index bits pick the entry.
//   pclk_i  system clock (>= 4x SCLK); all SPI pins are oversampled
//   prst_i  asynchronous active-high reset, also clears the register file
//   bus     spi_if.slave: SPI pins in, MISO/OE out, write notification out
module spi_target
  import spi_pkg::*;
#(
  parameter int WIDTH = spi_pkg::WIDTH,
  parameter int DEPTH = 8
) (
  input  logic  pclk_i,
  input  logic  prst_i,
  spi_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Pin order: [2] sclk, [1] cs_n, [0] mosi. CS idles high.
  localparam logic [2:0] PIN_IDLE = 3'b010;

  logic [2:0] pin_raw;
  logic [2:0] pin_level;
  logic [2:0] pin_rise;
  logic [2:0] pin_fall;

  assign pin_raw = {bus.sclk_i, bus.cs_n_i, bus.mosi_i};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    spi_sync_edge #(.RST_VAL(PIN_IDLE[gi])) u_sync (
      .pclk_i (pclk_i),
      .prst_i (prst_i),
      .din    (pin_raw[gi]),
      .level  (pin_level[gi]),
      .rise   (pin_rise[gi]),
      .fall   (pin_fall[gi])
    );
  end

  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_act;
  logic mosi_s;

  assign sclk_rise = pin_rise[2];
  assign sclk_fall = pin_fall[2];
  assign cs_rise   = pin_rise[1];
  assign cs_act    = ~pin_level[1];
  assign mosi_s    = pin_level[0];

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] rx_reg, rx_next;
  logic [WIDTH-1:0] tx_reg, tx_next;
  logic [WIDTH-1:0] addr_reg, addr_next;
  logic             miso_reg, miso_next;
  logic             wr_valid_reg, wr_valid_next;
  logic [WIDTH-1:0] wr_addr_reg, wr_addr_next;
  logic [WIDTH-1:0] wr_data_reg, wr_data_next;
  logic [WIDTH-1:0] regs [DEPTH];

  logic             we;
  logic [WIDTH-1:0] rx_shift;

  assign rx_shift = {rx_reg[WIDTH-2:0], mosi_s};

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rx_next       = rx_reg;
    tx_next       = tx_reg;
    addr_next     = addr_reg;
    miso_next     = miso_reg;
    wr_valid_next = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    we            = 1'b0;

    // CS release wins over everything, including a coincident final data
    // bit, so a transaction cut short never commits a write.
    if (cs_rise) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      miso_next  = 1'b0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (cs_act) begin
            state_next = S_ADDR;
            cnt_next   = '0;
            rx_next    = '0;
            miso_next  = 1'b0;
          end
        end

        S_ADDR: begin
          if (sclk_fall) miso_next = 1'b0;
          if (sclk_rise) begin
            rx_next  = rx_shift;
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == LAST_BIT) begin
              state_next = S_DATA;
              cnt_next   = '0;
              addr_next  = rx_shift;
              // Preload the read value so the first data-phase SCLK fall
              // can present its MSB immediately.
              if (rx_shift[RD_BIT] && addr_in_range(rx_shift[RD_BIT-1:0], DEPTH))
                tx_next = regs[rx_shift[IDX_W-1:0]];
              else
                tx_next = '0;
            end
          end
        end

        S_DATA: begin
          if (sclk_fall) begin
            if (addr_reg[RD_BIT]) begin
              miso_next = tx_reg[WIDTH-1];
              tx_next   = {tx_reg[WIDTH-2:0], 1'b0};
            end else begin
              miso_next = 1'b0;
            end
          end
          if (sclk_rise) begin
            rx_next  = rx_shift;
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == LAST_BIT) begin
              state_next = S_DONE;
              cnt_next   = '0;
              if (!addr_reg[RD_BIT] && addr_in_range(addr_reg[RD_BIT-1:0], DEPTH)) begin
                we            = 1'b1;
                wr_valid_next = 1'b1;
                wr_addr_next  = addr_reg;
                wr_data_next  = rx_shift;
              end
            end
          end
        end

        S_DONE: begin
          // Extra bytes under the same CS are ignored.
          if (sclk_fall) miso_next = 1'b0;
        end

        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      rx_reg       <= '0;
      tx_reg       <= '0;
      addr_reg     <= '0;
      miso_reg     <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rx_reg       <= rx_next;
      tx_reg       <= tx_next;
      addr_reg     <= addr_next;
      miso_reg     <= miso_next;
      wr_valid_reg <= wr_valid_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  // Register file is flop-based so reset can clear it.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we) begin
      regs[addr_reg[IDX_W-1:0]] <= rx_shift;
    end
  end

  assign bus.miso_o     = miso_reg;
  assign bus.miso_oe_o  = cs_act;
  assign bus.wr_valid_o = wr_valid_reg;
  assign bus.wr_addr_o  = wr_addr_reg;
  assign bus.wr_data_o  = wr_data_reg;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed bench for spi_target. Drives SPI mode 0 with SCLK
// at 1/12 of pclk, reads MISO just before each rising SCLK edge, and tracks
// every wr_valid_o pulse with a small monitor.
module tb_spi_target;

  logic pclk = 1'b0;
  logic prst = 1'b1;

  int checks   = 0;
  int failures = 0;

  int wr_high_cnt = 0;
  int wr_rise_cnt = 0;
  logic wv_prev = 1'b0;

  logic [7:0] rx;
  logic [7:0] dummy;
  int         base_cnt;

  spi_if #(.WIDTH(8)) bus ();

  spi_target #(.WIDTH(8), .DEPTH(8)) dut (
    .pclk_i (pclk),
    .prst_i (prst),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  // Count cycles with wr_valid high and distinct pulses; equal counts mean
  // every pulse lasted one cycle.
  always @(negedge pclk) begin
    if (bus.wr_valid_o === 1'b1) wr_high_cnt++;
    if (bus.wr_valid_o === 1'b1 && wv_prev !== 1'b1) wr_rise_cnt++;
    wv_prev = bus.wr_valid_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Send the top n bits of tx MSB first; rx collects MISO sampled just
  // before each rising SCLK edge.
  task automatic xbits(input logic [7:0] tx, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      bus.mosi_i = tx[i];
      wait_cyc(6);
      r[i] = bus.miso_o;
      bus.sclk_i = 1'b1;
      wait_cyc(6);
      bus.sclk_i = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.cs_n_i = 1'b0;
    wait_cyc(4);
  endtask

  task automatic cs_high();
    wait_cyc(6);
    bus.cs_n_i = 1'b1;
    wait_cyc(8);
  endtask

  task automatic xfer(input logic [7:0] a, input logic [7:0] d, output logic [7:0] r);
    logic [7:0] ign;
    cs_low();
    xbits(a, 8, ign);
    xbits(d, 8, r);
    cs_high();
  endtask

  initial begin
    bus.sclk_i = 1'b0;
    bus.cs_n_i = 1'b1;
    bus.mosi_i = 1'b0;

    // Reset state
    wait_cyc(3);
    chk("rst_miso",     {31'b0, bus.miso_o},     32'h0);
    chk("rst_miso_oe",  {31'b0, bus.miso_oe_o},  32'h0);
    chk("rst_wr_valid", {31'b0, bus.wr_valid_o}, 32'h0);
    chk("rst_wr_addr",  {24'b0, bus.wr_addr_o},  32'h0);
    chk("rst_wr_data",  {24'b0, bus.wr_data_o},  32'h0);
    prst = 1'b0;
    wait_cyc(5);

    // Write 0x05 <- 0x17
    base_cnt = wr_rise_cnt;
    cs_low();
    wait_cyc(2);
    chk("oe_cs_low", {31'b0, bus.miso_oe_o}, 32'h1);
    xbits(8'h05, 8, dummy);
    xbits(8'h17, 8, rx);
    chk("wr_miso_zero", {24'b0, rx}, 32'h00);
    cs_high();
    chk("oe_cs_high",     {31'b0, bus.miso_oe_o}, 32'h0);
    chk("wr_pulse_count", wr_rise_cnt - base_cnt, 32'd1);
    chk("wr_addr",        {24'b0, bus.wr_addr_o}, 32'h05);
    chk("wr_data",        {24'b0, bus.wr_data_o}, 32'h17);

    // Read back 0x05
    base_cnt = wr_rise_cnt;
    xfer(8'h85, 8'h00, rx);
    chk("rd_reg5",        {24'b0, rx}, 32'h17);
    chk("rd_no_pulse",    wr_rise_cnt - base_cnt, 32'd0);

    // Out-of-range write and read
    base_cnt = wr_rise_cnt;
    xfer(8'h0A, 8'h3C, rx);
    chk("oor_wr_no_pulse", wr_rise_cnt - base_cnt, 32'd0);
    chk("oor_wr_addr_held", {24'b0, bus.wr_addr_o}, 32'h05);
    xfer(8'h8A, 8'h00, rx);
    chk("oor_rd_zero", {24'b0, rx}, 32'h00);
    xfer(8'h82, 8'h00, rx);
    chk("oor_no_alias_reg2", {24'b0, rx}, 32'h00);

    // Abort after 4 data bits
    base_cnt = wr_rise_cnt;
    cs_low();
    xbits(8'h03, 8, dummy);
    xbits(8'hF0, 4, dummy);
    cs_high();
    chk("abort_no_pulse", wr_rise_cnt - base_cnt, 32'd0);
    xfer(8'h83, 8'h00, rx);
    chk("abort_reg3_unchanged", {24'b0, rx}, 32'h00);
    base_cnt = wr_rise_cnt;
    xfer(8'h03, 8'hC3, rx);
    chk("after_abort_pulse", wr_rise_cnt - base_cnt, 32'd1);
    chk("after_abort_data",  {24'b0, bus.wr_data_o}, 32'hC3);
    xfer(8'h83, 8'h00, rx);
    chk("after_abort_rd", {24'b0, rx}, 32'hC3);

    // Extra byte under one CS
    base_cnt = wr_rise_cnt;
    cs_low();
    xbits(8'h02, 8, dummy);
    xbits(8'h55, 8, dummy);
    xbits(8'hAA, 8, dummy);
    cs_high();
    chk("extra_one_pulse", wr_rise_cnt - base_cnt, 32'd1);
    chk("extra_wr_addr",   {24'b0, bus.wr_addr_o}, 32'h02);
    chk("extra_wr_data",   {24'b0, bus.wr_data_o}, 32'h55);
    xfer(8'h82, 8'h00, rx);
    chk("extra_rd_reg2", {24'b0, rx}, 32'h55);

    // Every pulse so far was exactly one cycle wide
    chk("pulse_width_1", wr_high_cnt, wr_rise_cnt);

    // Reset during the data phase of a read of 0x02 (0x55)
    cs_low();
    xbits(8'h82, 8, dummy);
    xbits(8'h00, 1, dummy);
    wait_cyc(6);
    chk("pre_rst_miso_bit6", {31'b0, bus.miso_o}, 32'h1);
    prst = 1'b1;
    #1;
    chk("midrst_miso",     {31'b0, bus.miso_o},     32'h0);
    chk("midrst_miso_oe",  {31'b0, bus.miso_oe_o},  32'h0);
    chk("midrst_wr_valid", {31'b0, bus.wr_valid_o}, 32'h0);
    chk("midrst_wr_addr",  {24'b0, bus.wr_addr_o},  32'h0);
    chk("midrst_wr_data",  {24'b0, bus.wr_data_o},  32'h0);
    bus.cs_n_i = 1'b1;
    wait_cyc(4);
    prst = 1'b0;
    wait_cyc(6);
    xfer(8'h85, 8'h00, rx);
    chk("post_rst_reg5", {24'b0, rx}, 32'h00);
    xfer(8'h83, 8'h00, rx);
    chk("post_rst_reg3", {24'b0, rx}, 32'h00);
    xfer(8'h82, 8'h00, rx);
    chk("post_rst_reg2", {24'b0, rx}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
